// File: rtl/disp_scan_bcd_pkg.sv
// disp_pkg: shared states, digit codes and BCD sizing for the scanned display
package disp_pkg;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  localparam logic [3:0] DIG_DASH = 4'd15;
  function automatic int nbcd(input int width);
    return (width * 3) / 10 + 1;
  endfunction
endpackage

// File: rtl/disp_scan_bcd_if.sv
// disp_scan_bcd_if: value/load request in, conversion status and scanned digit/anode out
//   value_i/load_i : conversion request (master drives)
//   busy_o/done_o  : conversion in progress / display register updated pulse
//   digito_o       : digit code for active slot (0-9, 15 = minus)
//   anode_o        : active-low one-cold anode enables
interface disp_scan_bcd_if #(parameter int WIDTH = 16, parameter int NDIG = 8);
  logic signed [WIDTH-1:0] value_i;
  logic load_i;
  logic busy_o;
  logic done_o;
  logic [3:0] digito_o;
  logic [NDIG-1:0] anode_o;
  modport master(output value_i, load_i, input busy_o, done_o, digito_o, anode_o);
  modport slave(input value_i, load_i, output busy_o, done_o, digito_o, anode_o);
endinterface

// File: rtl/disp_scan_bcd_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one iteration per clock
//   start/value : capture sign and magnitude when idle
//   busy/done   : not idle / one-cycle DONE state
//   commit      : last CONV cycle, bcd/sign hold the finished result
module bin2bcd_seq import disp_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int NBCD = nbcd(WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic signed [WIDTH-1:0] value,
  output logic busy,
  output logic done,
  output logic commit,
  output logic [NBCD*4-1:0] bcd,
  output logic sign
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  state_t state_q, state_d;
  logic [NBCD*4-1:0] bcd_q, bcd_d, adj;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sign_q, sign_d;
  always_comb begin
    for (int k = 0; k < NBCD; k++)
      adj[k*4 +: 4] = bcd_q[k*4 +: 4] >= 4'd5 ? bcd_q[k*4 +: 4] + 4'd3 : bcd_q[k*4 +: 4];
  end
  always_comb begin
    state_d = state_q;
    bcd_d = bcd_q;
    mag_d = mag_q;
    cnt_d = cnt_q;
    sign_d = sign_q;
    if (state_q == IDLE && start) begin
      state_d = CONV;
      sign_d = value[WIDTH-1];
      // unsigned reinterpretation makes -2^(WIDTH-1) come out as 2^(WIDTH-1)
      mag_d = value[WIDTH-1] ? WIDTH'(-value) : WIDTH'(value);
      bcd_d = '0;
      cnt_d = '0;
    end else if (state_q == CONV) begin
      if (cnt_q == LAST) state_d = DONE;
      else begin
        {bcd_d, mag_d} = {adj, mag_q} << 1;
        cnt_d = cnt_q + CW'(1);
      end
    end else if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcd_q <= '0;
      mag_q <= '0;
      cnt_q <= '0;
      sign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q <= bcd_d;
      mag_q <= mag_d;
      cnt_q <= cnt_d;
      sign_q <= sign_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign commit = state_q == CONV && cnt_q == LAST;
  assign bcd = bcd_q;
  assign sign = sign_q;
endmodule

// File: rtl/disp_scan_bcd.sv
// disp_scan_bcd: signed binary to BCD, held in a display register and scanned across NDIG anodes
//   clk/rst_n : clock, async active-low reset
//   bus       : value/load in, busy/done status, digit code and anode enables out
module disp_scan_bcd import disp_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int NDIG = 8,
  parameter int REFRESH_DIV = 100000
) (
  input logic clk,
  input logic rst_n,
  disp_scan_bcd_if.slave bus
);
  localparam int NBCD = nbcd(WIDTH);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(NDIG);
  localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SMAX = SW'(NDIG - 1);
  logic commit, sign;
  logic [NBCD*4-1:0] bcd, disp_q, disp_d;
  logic dsign_q, dsign_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [3:0] nib [NDIG];
  bin2bcd_seq #(.WIDTH(WIDTH), .NBCD(NBCD)) u_conv (
    .clk(clk),
    .rst_n(rst_n),
    .start(bus.load_i),
    .value(bus.value_i),
    .busy(bus.busy_o),
    .done(bus.done_o),
    .commit(commit),
    .bcd(bcd),
    .sign(sign)
  );
  always_comb begin
    disp_d = commit ? bcd : disp_q;
    dsign_d = commit ? sign : dsign_q;
    rcnt_d = rcnt_q == RMAX ? '0 : rcnt_q + RW'(1);
    slot_d = rcnt_q == RMAX ? (slot_q == SMAX ? '0 : slot_q + SW'(1)) : slot_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= '0;
      dsign_q <= 1'b0;
      rcnt_q <= '0;
      slot_q <= '0;
    end else begin
      disp_q <= disp_d;
      dsign_q <= dsign_d;
      rcnt_q <= rcnt_d;
      slot_q <= slot_d;
    end
  end
  for (genvar k = 0; k < NDIG; k++) begin : g_nib
    if (k < NBCD) begin : g_bcd
      assign nib[k] = disp_q[k*4 +: 4];
    end else if (k == NDIG - 1) begin : g_sign
      assign nib[k] = dsign_q ? DIG_DASH : 4'd0;
    end else begin : g_pad
      assign nib[k] = 4'd0;
    end
  end
  assign bus.digito_o = nib[slot_q];
  assign bus.anode_o = ~(NDIG'(1) << slot_q);
endmodule

// File: tb/tb_disp_scan_bcd.sv
// tb_disp_scan_bcd: randomized loads against a decimal-arithmetic model with a done-driven scoreboard
module tb_disp_scan_bcd;
  localparam int W = 16;
  localparam int ND = 8;
  localparam int RD = 4;
  typedef struct packed {
    logic [31:0] d;
    int due;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t q[$];
  logic [31:0] cur = '0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit active = 1'b0;
  int b_start = 0;
  always #5 clk = ~clk;
  disp_scan_bcd_if #(.WIDTH(W), .NDIG(ND)) bus();
  disp_scan_bcd #(.WIDTH(W), .NDIG(ND), .REFRESH_DIV(RD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  function automatic logic [31:0] digits(input int v);
    int m;
    logic [31:0] r;
    m = v < 0 ? -v : v;
    r = '0;
    for (int k = 0; k < 5; k++) r[k*4 +: 4] = 4'((m / (10 ** k)) % 10);
    r[31:28] = v < 0 ? 4'd15 : 4'd0;
    return r;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    int slot;
    exp_t e;
    logic [7:0] ea;
    slot = (cyc / RD) % ND;
    if (q.size() > 0 && cyc > q[0].due) begin
      total++;
      bad++;
      $display("FAIL done_missing: no done by cycle %0d at t=%0t", q[0].due, $time);
      void'(q.pop_front());
    end
    if (bus.done_o === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_unexpected: done=1 with nothing pending at t=%0t", $time);
      end else begin
        e = q.pop_front();
        check("done_time", cyc, e.due);
        cur = e.d;
      end
    end
    check("busy", bus.busy_o, active && cyc >= b_start && cyc <= b_start + 17);
    ea = ~(8'd1 << slot);
    check("anode", bus.anode_o, ea);
    check("digit", bus.digito_o, cur[slot*4 +: 4]);
  end
  task automatic do_load(input int v);
    @(negedge clk);
    bus.value_i = 16'(v);
    bus.load_i = 1'b1;
    @(posedge clk);
    #1;
    bus.load_i = 1'b0;
    if (!active || cyc >= b_start + 19) begin
      active = 1'b1;
      b_start = cyc;
      q.push_back('{d: digits(v), due: cyc + 17});
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    logic signed [15:0] r;
    bus.value_i = '0;
    bus.load_i = 1'b0;
    #1;
    check("rst_anode", bus.anode_o, 8'hFE);
    check("rst_digit", bus.digito_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    idle(3);
    rst_n = 1'b1;
    idle(40);
    do_load(1234);
    idle(50);
    do_load(-32768);
    idle(50);
    do_load(-1);
    idle(50);
    do_load(0);
    idle(40);
    do_load(32767);
    idle(40);
    do_load(500);
    idle(4);
    do_load(777);
    check("second_load_ignored", q.size(), 1);
    idle(50);
    for (int i = 0; i < 12; i++) begin
      r = 16'($urandom);
      do_load(int'(r));
      idle($urandom_range(15, 45));
    end
    idle(30);
    do_load(9999);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    active = 1'b0;
    cur = '0;
    #1;
    check("midrst_busy", bus.busy_o, 0);
    check("midrst_done", bus.done_o, 0);
    check("midrst_anode", bus.anode_o, 8'hFE);
    check("midrst_digit", bus.digito_o, 0);
    idle(2);
    rst_n = 1'b1;
    idle(5);
    do_load(42);
    idle(60);
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
